div_hilo_ctrl: RTL and testbench

Execute-stage controller for MIPS DIV/DIVU, sitting directly upstream of the unsigned divider wrapper `divu_fsm` and downstream of the EX operand muxes. It converts signed operands to magnitudes and launches the unsigned divide. It stalls EX until the result returns, then applies MIPS sign rules and writes the quotient to LO and the remainder to HI. Flushes abort the operation cleanly, and the abort is propagated to the divider.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_sign_fix.sv | 16 +
 rtl/div_hilo_ctrl.sv | 132 +++++++++++++
 tb/tb_div_hilo_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU execute-stage controller.
package div_pkg;

  localparam int unsigned DIV_W = 32;
  localparam logic [DIV_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_ISSUE = 2'd1,
    DIV_WAIT  = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  // Two's-complement negate when neg is set; 0x80000000 maps onto itself.
  function automatic logic [DIV_W-1:0] div_mag(input logic neg, input logic [DIV_W-1:0] v);
    return neg ? DIV_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Applies MIPS sign rules to the unsigned quotient/remainder from the divider.
module div_sign_fix
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] q,
  input  logic [DIV_W-1:0] r,
  input  logic             q_neg,
  input  logic             r_neg,
  output logic [DIV_W-1:0] lo,
  output logic [DIV_W-1:0] hi
);

  assign lo = div_mag(q_neg, q);
  assign hi = div_mag(r_neg, r);

endmodule

// File: rtl/div_hilo_ctrl.sv
// EX-stage DIV/DIVU controller: launches divu_fsm, stalls EX, writes HI/LO.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips the divider entirely.
module div_hilo_ctrl
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                div_req,
  input  logic                div_signed,
  input  logic [DATA_W-1:0]   rs_val,
  input  logic [DATA_W-1:0]   rt_val,
  output logic                stall,
  output logic                hi_we,
  output logic                lo_we,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic [DATA_W-1:0]   lo_wdata,
  output logic [DATA_W-1:0]   dv_src1,
  output logic [DATA_W-1:0]   dv_src2,
  output logic                dv_valid,
  output logic                dv_flush,
  input  logic [2*DATA_W-1:0] dv_out,
  input  logic                dv_res_valid
);

  div_state_e        state_q, state_d;
  logic [DIV_W-1:0]  src1_q, src1_d, src2_q, src2_d;
  logic [DIV_W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              dv_valid_q;
  logic              we_c;
  logic              zero_fast_c;
  logic [DIV_W-1:0]  fix_lo_c, fix_hi_c;

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast_c = (rt_val == '0);
`else
  assign zero_fast_c = 1'b0;
`endif

  div_sign_fix u_sign_fix (
    .q     (dv_out[2*DATA_W-1:DATA_W]),
    .r     (dv_out[DATA_W-1:0]),
    .q_neg (q_neg_q),
    .r_neg (r_neg_q),
    .lo    (fix_lo_c),
    .hi    (fix_hi_c)
  );

  // Next-state, operand capture and strobe decode.
  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    stall   = 1'b0;
    we_c    = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_req && !flush) begin
          stall = 1'b1;
          if (zero_fast_c) begin
            state_d = DIV_DONE;
            lo_d    = DIV_ZERO_LO;
            hi_d    = rs_val;
          end else begin
            state_d = DIV_ISSUE;
            src1_d  = div_mag(div_signed & rs_val[DIV_W-1], rs_val);
            src2_d  = div_mag(div_signed & rt_val[DIV_W-1], rt_val);
            q_neg_d = div_signed & (rs_val[DIV_W-1] ^ rt_val[DIV_W-1]);
            r_neg_d = div_signed & rs_val[DIV_W-1];
          end
        end
      end
      DIV_ISSUE: begin
        stall   = 1'b1;
        state_d = DIV_WAIT;
      end
      DIV_WAIT: begin
        stall = 1'b1;
        if (dv_res_valid && !flush) begin
          state_d = DIV_DONE;
          lo_d    = fix_lo_c;
          hi_d    = fix_hi_c;
        end
      end
      DIV_DONE: begin
        we_c    = ~flush;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= DIV_IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      dv_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      dv_valid_q <= (state_d == DIV_ISSUE);
    end
  end

  assign hi_we    = we_c;
  assign lo_we    = we_c;
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;
  assign dv_src1  = src1_q;
  assign dv_src2  = src2_q;
  assign dv_valid = dv_valid_q;
  assign dv_flush = flush;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural 34-cycle divider model.
module tb_div_hilo_ctrl;

  localparam int N = 34;

  logic        clk = 1'b0;
  logic        resetn, flush, div_req, div_signed;
  logic [31:0] rs_val, rt_val;
  logic        stall, hi_we, lo_we, dv_valid, dv_flush;
  logic [31:0] hi_wdata, lo_wdata, dv_src1, dv_src2;
  logic [63:0] dv_out;
  logic        dv_res_valid;

  int tests  = 0;
  int failed = 0;
  int cnt    = 0;
  int late_res = 0;

  always #5 clk = ~clk;

  div_hilo_ctrl dut (
    .clk(clk), .resetn(resetn), .flush(flush), .div_req(div_req),
    .div_signed(div_signed), .rs_val(rs_val), .rt_val(rt_val),
    .stall(stall), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .dv_src1(dv_src1), .dv_src2(dv_src2),
    .dv_valid(dv_valid), .dv_flush(dv_flush), .dv_out(dv_out),
    .dv_res_valid(dv_res_valid)
  );

  // Divider model: ignores flush, reset by resetn, samples operands late.
  always @(posedge clk) begin
    if (!resetn) begin
      cnt          <= 0;
      dv_res_valid <= 1'b0;
      dv_out       <= '0;
    end else begin
      dv_res_valid <= 1'b0;
      if (dv_valid) begin
        cnt <= N - 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          dv_res_valid <= 1'b1;
          if (dv_src2 == 0) dv_out <= {32'hFFFF_FFFF, dv_src1};
          else              dv_out <= {dv_src1 / dv_src2, dv_src1 % dv_src2};
        end
      end
    end
  end

  always @(posedge clk) if (dv_res_valid && !stall) late_res <= late_res + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_div(input string name, input logic sgn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input int estall, input logic evalid);
    int stalls = 0;
    int vcyc   = -1;
    logic done = 1'b0;
    div_req = 1'b1; div_signed = sgn; rs_val = rs; rt_val = rt;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (stall) stalls++;
      if (dv_valid && vcyc < 0) begin
        vcyc = c;
        chk({name, " src1"}, 64'(dv_src1), 64'(e1));
        chk({name, " src2"}, 64'(dv_src2), 64'(e2));
      end
      if (hi_we) begin
        done = 1'b1;
        chk({name, " lo_we"}, 64'(lo_we), 64'd1);
        chk({name, " lo"}, 64'(lo_wdata), 64'(elo));
        chk({name, " hi"}, 64'(hi_wdata), 64'(ehi));
        chk({name, " stall_done"}, 64'(stall), 64'd0);
      end
      @(negedge clk);
    end
    chk({name, " completed"}, 64'(done), 64'd1);
    chk({name, " stall_cycles"}, 64'(stalls), 64'(estall));
    chk({name, " valid_seen_c1"}, 64'(vcyc == 1), 64'(evalid));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    resetn = 1'b0; flush = 1'b1; div_req = 1'b0; div_signed = 1'b0;
    rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst we", 64'({hi_we, lo_we}), 64'd0);
    chk("rst valid", 64'(dv_valid), 64'd0);
    chk("rst wdata", {hi_wdata, lo_wdata}, 64'd0);
    chk("rst src", {dv_src1, dv_src2}, 64'd0);
    chk("rst dv_flush", 64'(dv_flush), 64'd1);
    @(negedge clk);
    resetn = 1'b1; flush = 1'b0;
    @(negedge clk);

    do_div("divu100_7", 1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 32'd14, 32'd2, 36, 1'b1);
    div_req = 1'b0; #1;
    chk("hold lo", 64'(lo_wdata), 64'd14);
    @(negedge clk);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 36, 1'b1);
    div_req = 1'b0; @(negedge clk);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
           32'h8000_0000, 32'd0, 36, 1'b1);
    div_req = 1'b0; @(negedge clk);

    // Flush in the 10th WAIT cycle; the divider result still arrives later.
    div_req = 1'b1; div_signed = 1'b0; rs_val = 32'd100; rt_val = 32'd7;
    repeat (11) @(negedge clk);
    flush = 1'b1; #1;
    chk("flush dv_flush", 64'(dv_flush), 64'd1);
    chk("flush no_we", 64'(hi_we), 64'd0);
    @(negedge clk);
    flush = 1'b0; div_req = 1'b0; #1;
    chk("flush dv_flush_low", 64'(dv_flush), 64'd0);
    chk("flush stall", 64'(stall), 64'd0);
    we_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hi_we || lo_we || stall || dv_valid) we_seen++;
    end
    chk("flush quiet", 64'(we_seen), 64'd0);
    chk("flush late_res", 64'(late_res), 64'd1);
    @(negedge clk);
    do_div("divu9_3", 1'b0, 32'd9, 32'd3, 32'd9, 32'd3, 32'd3, 32'd0, 36, 1'b1);
    div_req = 1'b0; @(negedge clk);

`ifdef DIV_ZERO_FAST_EN
    do_div("divu5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 1'b0);
`else
    do_div("divu5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 36, 1'b1);
`endif
    div_req = 1'b0; @(negedge clk);

    // Reset during WAIT, then back-to-back DIV and DIVU.
    div_req = 1'b1; div_signed = 1'b1; rs_val = 32'd50; rt_val = 32'd6;
    repeat (6) @(negedge clk);
    resetn = 1'b0; div_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1; #1;
    chk("rst_mid stall", 64'(stall), 64'd0);
    chk("rst_mid valid", 64'(dv_valid), 64'd0);
    chk("rst_mid lo", 64'(lo_wdata), 64'd0);
    @(negedge clk);
    do_div("b2b_div", 1'b1, 32'd50, 32'hFFFF_FFFA, 32'd50, 32'd6,
           32'hFFFF_FFF8, 32'd2, 36, 1'b1);
    do_div("b2b_divu", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'hFFFF_FFFF, 32'd16,
           32'h0FFF_FFFF, 32'd15, 36, 1'b1);
    div_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
